// File: rtl/tick_capture_pkg.sv
// Shared constants and helpers for the tick_capture period counter and
// event timestamp channels.
package tick_capture_pkg;

  localparam int TC_PERIOD_DEFAULT = 25000000;
  localparam int TC_WIDTH_DEFAULT  = 25;
  localparam int TC_CHANNELS_MAX   = 16;
  localparam int TC_WARMUP         = 3;

  // Base bit index of channel ch inside the flattened cap_data bus.
  function automatic int tc_slice_base(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/evt_edge_sync.sv
// Per-channel event front end: two-flop synchronizer, previous-value flop
// and a maskable either-edge detector.
module evt_edge_sync
  import tick_capture_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic evt,
  input  logic mask,
  output logic evt_edge
);

  logic s1;
  logic s2;
  logic prev;

  // prev keeps following s2 while masked so the first unmasked compare
  // only sees genuine changes, not the reset-to-level transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= evt;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign evt_edge = (s2 != prev) && !mask;

endmodule

// File: rtl/tick_capture.sv
// Programmable period counter with tick/upd outputs plus per-channel
// event timestamp capture with valid/ack handoff and sticky overflow.
module tick_capture
  import tick_capture_pkg::*;
#(
  parameter int PERIOD   = TC_PERIOD_DEFAULT,
  parameter int WIDTH    = TC_WIDTH_DEFAULT,
  parameter int CHANNELS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        period_ld,
  input  logic [WIDTH-1:0]            period_val,
  input  logic [CHANNELS-1:0]         evt,
  input  logic [CHANNELS-1:0]         cap_ack,
  output logic [WIDTH-1:0]            count,
  output logic                        tick,
  output logic                        upd,
  output logic [CHANNELS-1:0]         cap_valid,
  output logic [CHANNELS*WIDTH-1:0]   cap_data,
  output logic [CHANNELS-1:0]         cap_ovf
);

  logic [WIDTH-1:0] period_q;
  logic             ld_ok;
  logic             wrap;
  logic [1:0]       warm;
  logic             mask;

  assign ld_ok = period_ld && (period_val >= WIDTH'(2));
  assign wrap  = en && (count == period_q - WIDTH'(1));

  // A legal reload restarts the count and swallows any wrap due this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= WIDTH'(PERIOD);
      count    <= '0;
      tick     <= 1'b0;
      upd      <= 1'b0;
    end else if (ld_ok) begin
      period_q <= period_val;
      count    <= '0;
      tick     <= 1'b0;
    end else if (wrap) begin
      count    <= '0;
      tick     <= 1'b1;
      upd      <= ~upd;
    end else if (en) begin
      count    <= count + WIDTH'(1);
      tick     <= 1'b0;
    end else begin
      tick     <= 1'b0;
    end
  end

  assign mask = (warm != 2'(TC_WARMUP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm <= 2'd0;
    end else if (mask) begin
      warm <= warm + 2'd1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam int Base = tc_slice_base(i, WIDTH);

    logic             hit;
    logic             v;
    logic             o;
    logic [WIDTH-1:0] d;

    evt_edge_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .evt      (evt[i]),
      .mask     (mask),
      .evt_edge (hit)
    );

    // First event wins while valid; an ack in the same cycle frees the slot.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v <= 1'b0;
        o <= 1'b0;
        d <= '0;
      end else if (hit) begin
        if (!v || cap_ack[i]) begin
          d <= count;
          v <= 1'b1;
          o <= 1'b0;
        end else begin
          o <= 1'b1;
        end
      end else if (cap_ack[i] && v) begin
        v <= 1'b0;
        o <= 1'b0;
      end
    end

    assign cap_valid[i]           = v;
    assign cap_ovf[i]             = o;
    assign cap_data[Base +: WIDTH] = d;
  end

endmodule

// File: tb/tb_tick_capture.sv
// Directed plus randomized bench for tick_capture, checked every cycle
// against a cycle-level behavioural model built from the block's rules.
module tb_tick_capture;

  localparam int P  = 8;
  localparam int W  = 8;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          period_ld = 1'b0;
  logic [W-1:0]  period_val = '0;
  logic [CH-1:0] evt = '0;
  logic [CH-1:0] cap_ack = '0;
  logic [W-1:0]  count;
  logic          tick;
  logic          upd;
  logic [CH-1:0] cap_valid;
  logic [CH*W-1:0] cap_data;
  logic [CH-1:0] cap_ovf;

  int errors = 0;
  int checks = 0;

  tick_capture #(.PERIOD(P), .WIDTH(W), .CHANNELS(CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .period_ld  (period_ld),
    .period_val (period_val),
    .evt        (evt),
    .cap_ack    (cap_ack),
    .count      (count),
    .tick       (tick),
    .upd        (upd),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .cap_ovf    (cap_ovf)
  );

  always #5 clk = ~clk;

  // Reference model state; hist holds the evt values sampled at the last
  // three clock edges, oldest first.
  int            m_count;
  int            m_period;
  logic          m_tick;
  logic          m_upd;
  logic [CH-1:0] m_valid;
  logic [CH-1:0] m_ovf;
  int            m_data[CH];
  logic [CH-1:0] hist[$];
  int            edges_since_rst;

  task automatic model_reset();
    m_count = 0;
    m_period = P;
    m_tick = 1'b0;
    m_upd = 1'b0;
    m_valid = '0;
    m_ovf = '0;
    foreach (m_data[i]) m_data[i] = 0;
    hist.delete();
    repeat (3) hist.push_back('0);
    edges_since_rst = 0;
  endtask

  // An evt change sampled at edge n is acted on at edge n+2; the first
  // three edges after reset never capture.
  task automatic model_step();
    logic [CH-1:0] ev;
    if (rst) return;
    edges_since_rst++;
    ev = (edges_since_rst > 3) ? (hist[1] ^ hist[0]) : '0;
    for (int i = 0; i < CH; i++) begin
      if (ev[i]) begin
        if (!m_valid[i] || cap_ack[i]) begin
          m_data[i] = m_count;
          m_valid[i] = 1'b1;
          m_ovf[i] = 1'b0;
        end else begin
          m_ovf[i] = 1'b1;
        end
      end else if (cap_ack[i] && m_valid[i]) begin
        m_valid[i] = 1'b0;
        m_ovf[i] = 1'b0;
      end
    end
    if (period_ld && period_val >= 2) begin
      m_period = period_val;
      m_count = 0;
      m_tick = 1'b0;
    end else if (en) begin
      if (m_count == m_period - 1) begin
        m_count = 0;
        m_tick = 1'b1;
        m_upd = !m_upd;
      end else begin
        m_count = m_count + 1;
        m_tick = 1'b0;
      end
    end else begin
      m_tick = 1'b0;
    end
    hist.push_back(evt);
    void'(hist.pop_front());
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("count", 32'(count), 32'(m_count));
    check("tick", 32'(tick), 32'(m_tick));
    check("upd", 32'(upd), 32'(m_upd));
    check("cap_valid", 32'(cap_valid), 32'(m_valid));
    check("cap_ovf", 32'(cap_ovf), 32'(m_ovf));
    for (int i = 0; i < CH; i++)
      check($sformatf("cap_data%0d", i), 32'(cap_data[i*W +: W]), 32'(m_data[i]));
  endtask

  // One clock: model follows the rising edge, compare on the falling edge.
  task automatic apply_stimulus();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_output();
  endtask

  task automatic wait_for_count(input int v);
    for (int k = 0; k < 40 && m_count != v; k++) apply_stimulus();
    check("wait_count", 32'(m_count), 32'(v));
  endtask

  task automatic release_reset();
    @(negedge clk);
    model_reset();
    check_output();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_output();
    rst = 1'b0;

    $display("[TB] period and tick");
    for (int c = 1; c <= 20; c++) begin
      apply_stimulus();
      check("seq_count", 32'(count), 32'(c % 8));
      check("seq_tick", 32'(tick), 32'(c % 8 == 0));
      check("seq_upd", 32'(upd), 32'((c / 8) % 2));
    end

    $display("[TB] enable and reload");
    wait_for_count(5);
    en = 1'b0;
    repeat (4) begin
      apply_stimulus();
      check("hold_count", 32'(count), 32'd5);
      check("hold_tick", 32'(tick), 32'd0);
    end
    en = 1'b1;
    wait_for_count(6);
    period_ld = 1'b1;
    period_val = 8'd3;
    apply_stimulus();
    check("reload_count", 32'(count), 32'd0);
    check("reload_tick", 32'(tick), 32'd0);
    period_ld = 1'b0;
    repeat (6) apply_stimulus();
    period_ld = 1'b1;
    period_val = 8'd1;
    apply_stimulus();
    period_ld = 1'b0;
    repeat (4) apply_stimulus();
    period_ld = 1'b1;
    period_val = 8'd8;
    apply_stimulus();
    period_ld = 1'b0;

    $display("[TB] single capture");
    wait_for_count(1);
    evt[2] = ~evt[2];
    repeat (3) apply_stimulus();
    check("single_valid", 32'(cap_valid[2]), 32'd1);
    check("single_data", 32'(cap_data[2*W +: W]), 32'd3);
    cap_ack[2] = 1'b1;
    apply_stimulus();
    cap_ack[2] = 1'b0;
    check("single_ack", 32'(cap_valid[2]), 32'd0);

    $display("[TB] overflow and ack with edge");
    evt[0] = ~evt[0];
    repeat (4) apply_stimulus();
    evt[0] = ~evt[0];
    repeat (4) apply_stimulus();
    check("ovf_set", 32'(cap_ovf[0]), 32'd1);
    evt[0] = ~evt[0];
    repeat (2) apply_stimulus();
    cap_ack[0] = 1'b1;
    apply_stimulus();
    cap_ack[0] = 1'b0;
    check("ackedge_valid", 32'(cap_valid[0]), 32'd1);
    check("ackedge_ovf", 32'(cap_ovf[0]), 32'd0);
    repeat (2) apply_stimulus();

    $display("[TB] reset behaviour");
    evt = 4'b1111;
    rst = 1'b1;
    #1;
    model_reset();
    repeat (2) apply_stimulus();
    release_reset();
    repeat (8) apply_stimulus();
    check("held_evt_valid", 32'(cap_valid), 32'd0);
    evt = 4'b1010;
    repeat (3) apply_stimulus();
    check("pre_rst_valid", 32'(cap_valid), 32'h5);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_upd", 32'(upd), 32'd0);
    check("arst_valid", 32'(cap_valid), 32'd0);
    check("arst_data", cap_data, 32'd0);
    check("arst_ovf", 32'(cap_ovf), 32'd0);
    model_reset();
    release_reset();
    repeat (5) apply_stimulus();

    $display("[TB] simultaneous events");
    wait_for_count(5);
    evt = ~evt;
    repeat (3) apply_stimulus();
    check("simul_valid", 32'(cap_valid), 32'hf);
    for (int i = 0; i < CH; i++)
      check($sformatf("simul_data%0d", i), 32'(cap_data[i*W +: W]), 32'd7);
    cap_ack = 4'hf;
    apply_stimulus();
    cap_ack = '0;

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 7) != 0);
      period_ld = ($urandom_range(0, 24) == 0);
      period_val = W'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) evt = evt ^ CH'($urandom_range(1, 15));
      cap_ack = CH'($urandom_range(0, 15)) & CH'($urandom_range(0, 15));
      apply_stimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
